// File: rtl/brush_paint_ctrl.sv
// Brush painter and canvas clear sequencer sharing one frame-buffer port.
// The display read port has absolute priority; painter/clear hold while it is granted.
module brush_paint_ctrl #(
    parameter int CANVAS_W = 160,
    parameter int CANVAS_H = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        updateConfig,
    input  logic        updatePosition,
    input  logic        brush,
    input  logic [2:0]  newColorUpdate,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic        clearReq,
    input  logic        vgaReq,
    input  logic [14:0] vgaAddr,
    output logic [14:0] memAddr,
    output logic        memWe,
    output logic [2:0]  memWData,
    output logic        vgaGrant,
    output logic        busy,
    output logic        dropped
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PAINT = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;

    localparam int          NPIX      = CANVAS_W * CANVAS_H;
    localparam logic [14:0] LAST_ADDR = 15'(NPIX - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  color_q, color_d;
    logic        size_q, size_d;
    logic [2:0]  scolor_q, scolor_d;
    logic        ssize_q, ssize_d;
    logic [7:0]  cx_q, cx_d;
    logic [7:0]  cy_q, cy_d;
    logic [1:0]  row_q, row_d;
    logic [1:0]  col_q, col_d;
    logic        pend_q, pend_d;
    logic [7:0]  pend_x_q, pend_x_d;
    logic [7:0]  pend_y_q, pend_y_d;
    logic [14:0] clr_q, clr_d;
    logic        drop_q, drop_d;

    logic signed [8:0] off_x, off_y;
    logic signed [8:0] px, py;
    logic              in_canvas;
    logic [14:0]       pix_addr;
    logic              last_visit;
    logic              start;
    logic [7:0]        sx, sy;

    // Brush offsets run -r..+r, so the counter value is shifted by r.
    always_comb begin
        off_x = $signed({7'b0, col_q}) - (ssize_q ? 9'sd1 : 9'sd0);
        off_y = $signed({7'b0, row_q}) - (ssize_q ? 9'sd1 : 9'sd0);
        px = $signed({1'b0, cx_q}) + off_x;
        py = $signed({1'b0, cy_q}) + off_y;
        in_canvas = (int'(px) >= 0) && (int'(px) < CANVAS_W) &&
                    (int'(py) >= 0) && (int'(py) < CANVAS_H);
        pix_addr = 15'(int'(py) * CANVAS_W + int'(px));
        last_visit = ssize_q ? ((row_q == 2'd2) && (col_q == 2'd2)) : 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        color_d  = updateConfig ? newColorUpdate : color_q;
        size_d   = updateConfig ? brush : size_q;
        scolor_d = scolor_q;
        ssize_d  = ssize_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        row_d    = row_q;
        col_d    = col_q;
        pend_d   = pend_q;
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        clr_d    = clr_q;
        drop_d   = 1'b0;
        start    = 1'b0;
        sx       = x;
        sy       = y;

        if (clearReq) begin
            state_d = CLEAR;
            clr_d   = '0;
            pend_d  = 1'b0;
            row_d   = '0;
            col_d   = '0;
            drop_d  = updatePosition || ((state_q == PAINT) && pend_q);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (updatePosition) begin
                        start = 1'b1;
                    end
                end
                PAINT: begin
                    if (!vgaReq && last_visit) begin
                        if (pend_q) begin
                            start  = 1'b1;
                            sx     = pend_x_q;
                            sy     = pend_y_q;
                            pend_d = 1'b0;
                            if (updatePosition) begin
                                pend_d   = 1'b1;
                                pend_x_d = x;
                                pend_y_d = y;
                            end
                        end else if (updatePosition) begin
                            start = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        if (!vgaReq) begin
                            if (col_q == 2'd2) begin
                                col_d = '0;
                                row_d = row_q + 2'd1;
                            end else begin
                                col_d = col_q + 2'd1;
                            end
                        end
                        if (updatePosition) begin
                            pend_d   = 1'b1;
                            pend_x_d = x;
                            pend_y_d = y;
                            drop_d   = pend_q;
                        end
                    end
                end
                CLEAR: begin
                    drop_d = updatePosition;
                    if (!vgaReq) begin
                        if (clr_q == LAST_ADDR) begin
                            state_d = IDLE;
                            clr_d   = '0;
                        end else begin
                            clr_d = clr_q + 15'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Stroke config is snapshotted here so later updates cannot leak in.
        if (start) begin
            state_d  = PAINT;
            cx_d     = sx;
            cy_d     = sy;
            row_d    = '0;
            col_d    = '0;
            scolor_d = color_d;
            ssize_d  = size_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            color_q  <= 3'b111;
            size_q   <= 1'b0;
            scolor_q <= 3'b111;
            ssize_q  <= 1'b0;
            cx_q     <= '0;
            cy_q     <= '0;
            row_q    <= '0;
            col_q    <= '0;
            pend_q   <= 1'b0;
            pend_x_q <= '0;
            pend_y_q <= '0;
            clr_q    <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            color_q  <= color_d;
            size_q   <= size_d;
            scolor_q <= scolor_d;
            ssize_q  <= ssize_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            row_q    <= row_d;
            col_q    <= col_d;
            pend_q   <= pend_d;
            pend_x_q <= pend_x_d;
            pend_y_q <= pend_y_d;
            clr_q    <= clr_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        memAddr  = '0;
        memWe    = 1'b0;
        memWData = 3'b000;
        if (vgaReq) begin
            memAddr = vgaAddr;
        end else if (state_q == CLEAR) begin
            memAddr = clr_q;
            memWe   = 1'b1;
        end else if (state_q == PAINT) begin
            memAddr  = pix_addr;
            memWe    = in_canvas;
            memWData = scolor_q;
        end
    end

    assign vgaGrant = vgaReq;
    assign busy     = (state_q != IDLE);
    assign dropped  = drop_q;

endmodule

// File: tb/tb_brush_paint_ctrl.sv
// Directed bench for brush_paint_ctrl: cycle table plus multi-cycle sequences.
module tb_brush_paint_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        updateConfig = 1'b0;
    logic        updatePosition = 1'b0;
    logic        brush = 1'b0;
    logic [2:0]  newColorUpdate = 3'b000;
    logic [7:0]  x = 8'd0;
    logic [7:0]  y = 8'd0;
    logic        clearReq = 1'b0;
    logic        vgaReq = 1'b0;
    logic [14:0] vgaAddr = 15'd0;
    logic [14:0] memAddr;
    logic        memWe;
    logic [2:0]  memWData;
    logic        vgaGrant;
    logic        busy;
    logic        dropped;

    int errors = 0;
    int checks = 0;

    brush_paint_ctrl #(.CANVAS_W(160), .CANVAS_H(120)) dut (
        .clk(clk), .reset(reset),
        .updateConfig(updateConfig), .updatePosition(updatePosition),
        .brush(brush), .newColorUpdate(newColorUpdate),
        .x(x), .y(y), .clearReq(clearReq),
        .vgaReq(vgaReq), .vgaAddr(vgaAddr),
        .memAddr(memAddr), .memWe(memWe), .memWData(memWData),
        .vgaGrant(vgaGrant), .busy(busy), .dropped(dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cfg;
        logic        pos;
        logic        br;
        logic [2:0]  col;
        logic [7:0]  px;
        logic [7:0]  py;
        logic        vga;
        logic [14:0] vaddr;
        logic        ewe;
        logic [14:0] eaddr;
        logic [2:0]  edata;
        logic        ebusy;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic cfg, input logic pos, input logic br,
                                input logic [2:0] col, input logic [7:0] px,
                                input logic [7:0] py, input logic vga,
                                input logic [14:0] vaddr, input logic ewe,
                                input logic [14:0] eaddr, input logic [2:0] edata,
                                input logic ebusy);
        vec_t v;
        v.cfg = cfg; v.pos = pos; v.br = br; v.col = col;
        v.px = px; v.py = py; v.vga = vga; v.vaddr = vaddr;
        v.ewe = ewe; v.eaddr = eaddr; v.edata = edata; v.ebusy = ebusy;
        return v;
    endfunction

    logic [14:0] wq[$];
    int nb, nd, idx, bad;
    logic found;

    initial begin
        tbl[0]  = mk(0, 0, 0, 3'b000, 0,  0,  0, 0,    0, 0,    0,      0);
        tbl[1]  = mk(1, 0, 0, 3'b010, 0,  0,  0, 0,    0, 0,    0,      0);
        tbl[2]  = mk(0, 1, 0, 3'b000, 5,  2,  0, 0,    0, 0,    0,      0);
        tbl[3]  = mk(0, 0, 0, 3'b000, 0,  0,  0, 0,    1, 325,  3'b010, 1);
        tbl[4]  = mk(0, 0, 0, 3'b000, 0,  0,  1, 1234, 0, 1234, 0,      0);
        tbl[5]  = mk(1, 0, 1, 3'b011, 0,  0,  0, 0,    0, 0,    0,      0);
        tbl[6]  = mk(0, 1, 0, 3'b000, 10, 10, 0, 0,    0, 0,    0,      0);
        tbl[7]  = mk(0, 0, 0, 3'b000, 0,  0,  0, 0,    1, 1449, 3'b011, 1);
        tbl[8]  = mk(0, 0, 0, 3'b000, 0,  0,  0, 0,    1, 1450, 3'b011, 1);
        tbl[9]  = mk(0, 0, 0, 3'b000, 0,  0,  0, 0,    1, 1451, 3'b011, 1);
        tbl[10] = mk(0, 0, 0, 3'b000, 0,  0,  1, 7777, 0, 7777, 0,      1);
        tbl[11] = mk(0, 0, 0, 3'b000, 0,  0,  1, 7777, 0, 7777, 0,      1);
        tbl[12] = mk(1, 0, 1, 3'b101, 0,  0,  1, 7777, 0, 7777, 0,      1);
        tbl[13] = mk(0, 0, 0, 3'b000, 0,  0,  1, 7777, 0, 7777, 0,      1);
        tbl[14] = mk(0, 0, 0, 3'b000, 0,  0,  0, 0,    1, 1609, 3'b011, 1);
        tbl[15] = mk(0, 0, 0, 3'b000, 0,  0,  0, 0,    1, 1610, 3'b011, 1);
        tbl[16] = mk(0, 0, 0, 3'b000, 0,  0,  0, 0,    1, 1611, 3'b011, 1);
        tbl[17] = mk(0, 0, 0, 3'b000, 0,  0,  0, 0,    1, 1769, 3'b011, 1);
        tbl[18] = mk(0, 0, 0, 3'b000, 0,  0,  0, 0,    1, 1770, 3'b011, 1);
        tbl[19] = mk(0, 0, 0, 3'b000, 0,  0,  0, 0,    1, 1771, 3'b011, 1);
        tbl[20] = mk(0, 0, 0, 3'b000, 0,  0,  0, 0,    0, 0,    0,      0);

        @(negedge clk);
        chk("rst_we", memWe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dropped", dropped, 0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            updateConfig   = tbl[i].cfg;
            updatePosition = tbl[i].pos;
            brush          = tbl[i].br;
            newColorUpdate = tbl[i].col;
            x              = tbl[i].px;
            y              = tbl[i].py;
            vgaReq         = tbl[i].vga;
            vgaAddr        = tbl[i].vaddr;
            @(negedge clk);
            chk($sformatf("v%0d_grant", i), vgaGrant, tbl[i].vga);
            chk($sformatf("v%0d_we", i), memWe, tbl[i].ewe);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].ebusy);
            if (tbl[i].ewe || tbl[i].vga)
                chk($sformatf("v%0d_addr", i), memAddr, tbl[i].eaddr);
            if (tbl[i].ewe)
                chk($sformatf("v%0d_data", i), memWData, tbl[i].edata);
            tick();
        end
        updateConfig = 0; updatePosition = 0; vgaReq = 0;

        // 3x3 at corner (0,0): 9 visits, only 4 in-canvas writes
        updatePosition = 1; x = 0; y = 0;
        tick();
        updatePosition = 0;
        nb = 0; wq.delete();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy) break;
            nb++;
            if (memWe) wq.push_back(memAddr);
            tick();
        end
        chk("corner_busy", nb, 9);
        chk("corner_nwr", wq.size(), 4);
        if (wq.size() == 4) begin
            chk("corner_w0", wq[0], 0);
            chk("corner_w1", wq[1], 1);
            chk("corner_w2", wq[2], 160);
            chk("corner_w3", wq[3], 161);
        end
        tick();

        // Three position pulses: start, pending, overwrite with one drop
        updateConfig = 1; newColorUpdate = 3'b110; brush = 1;
        tick();
        updateConfig = 0;
        nb = 0; nd = 0; wq.delete();
        for (int k = 0; k < 40; k++) begin
            updatePosition = (k < 3);
            x = (k == 0) ? 8'd20 : (k == 1) ? 8'd30 : 8'd50;
            y = x;
            @(negedge clk);
            if (k > 0 && !busy) break;
            if (busy) nb++;
            if (memWe) wq.push_back(memAddr);
            if (dropped) nd++;
            tick();
            updatePosition = 0;
        end
        chk("pend_busy", nb, 18);
        chk("pend_drops", nd, 1);
        chk("pend_nwr", wq.size(), 18);
        if (wq.size() == 18) begin
            chk("pend_first", wq[0], 3059);
            chk("pend_s2_first", wq[9], 7889);
            chk("pend_s2_last", wq[17], 8211);
        end
        tick();

        // Clear aborting a stroke that holds a pending position
        for (int k = 0; k < 4; k++) begin
            updatePosition = (k == 0) || (k == 1);
            x = (k == 0) ? 8'd60 : 8'd70;
            y = x;
            clearReq = (k == 3);
            tick();
        end
        updatePosition = 0; clearReq = 0;
        idx = 0; bad = 0; nb = 0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (k == 0) chk("clr_dropped", dropped, 1);
            if (!busy) break;
            nb++;
            if (memWe) begin
                if (memAddr !== 15'(idx) || memWData !== 3'b000) bad++;
                idx++;
            end
            tick();
        end
        chk("clr_writes", idx, 19200);
        chk("clr_cycles", nb, 19200);
        chk("clr_bad", bad, 0);
        chk("clr_idle", busy, 0);
        tick();

        // Reset during clear at address 500
        updateConfig = 1; newColorUpdate = 3'b100; brush = 0;
        tick();
        updateConfig = 0;
        clearReq = 1;
        tick();
        clearReq = 0;
        found = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (memWe && memAddr == 15'd500) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("rst500_found", found, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst500_we", memWe, 0);
        chk("rst500_busy", busy, 0);
        @(negedge clk);
        chk("rst500_we_hold", memWe, 0);
        tick();
        reset = 1'b0;
        updatePosition = 1; x = 1; y = 1;
        tick();
        updatePosition = 0;
        @(negedge clk);
        chk("post_rst_we", memWe, 1);
        chk("post_rst_addr", memAddr, 161);
        chk("post_rst_color", memWData, 3'b111);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
